// File: rtl/load_store_unit_if.sv
// Data-memory request/ack bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: lane steering, req/ack memory handshake, load extension and timeout.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      mem_rw,
    input  logic [1:0]                mem_width,
    input  logic                      mem_unsigned,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               rdata,
    output logic                      err,
    load_store_unit_if.master         mem
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              lat_rw_q,    lat_rw_d;
    logic [1:0]        lat_width_q, lat_width_d;
    logic              lat_uns_q,   lat_uns_d;
    logic [1:0]        lat_off_q,   lat_off_d;

    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              req_q,       req_d;
    logic              we_q,        we_d;
    logic [DATA_W-1:0] maddr_q,     maddr_d;
    logic [BE_W-1:0]   be_q,        be_d;
    logic [DATA_W-1:0] mwdata_q,    mwdata_d;

    logic [1:0]        width_n_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wlane_c;
    logic              misalign_c;
    logic [7:0]        load_byte_c;
    logic [15:0]       load_half_c;
    logic [DATA_W-1:0] load_ext_c;

    // Request-side steering from the live pipeline inputs; width 3 behaves as word.
    always_comb begin
        width_n_c = (mem_width == 2'd3) ? W_WORD : mem_width;
        be_c      = 4'b1111;
        wlane_c   = wdata;
        case (width_n_c)
            W_BYTE: begin
                be_c    = BE_W'(4'b0001 << addr[1:0]);
                wlane_c = {4{wdata[7:0]}};
            end
            W_HALF: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wlane_c = wdata;
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = ((width_n_c == W_HALF) && addr[0]) ||
                     ((width_n_c == W_WORD) && (addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
    end

    // Response-side lane select and sign/zero extension from the latched request.
    always_comb begin
        case (lat_off_q)
            2'd0:    load_byte_c = mem.mem_rdata[7:0];
            2'd1:    load_byte_c = mem.mem_rdata[15:8];
            2'd2:    load_byte_c = mem.mem_rdata[23:16];
            default: load_byte_c = mem.mem_rdata[31:24];
        endcase
        load_half_c = lat_off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (lat_width_q)
            W_BYTE:  load_ext_c = {{24{~lat_uns_q & load_byte_c[7]}}, load_byte_c};
            W_HALF:  load_ext_c = {{16{~lat_uns_q & load_half_c[15]}}, load_half_c};
            default: load_ext_c = mem.mem_rdata;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_rw_d    = lat_rw_q;
        lat_width_d = lat_width_q;
        lat_uns_d   = lat_uns_q;
        lat_off_d   = lat_off_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        we_d        = we_q;
        maddr_d     = maddr_q;
        be_d        = be_q;
        mwdata_d    = mwdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lat_rw_d    = mem_rw;
                    lat_width_d = width_n_c;
                    lat_uns_d   = mem_unsigned;
                    lat_off_d   = addr[1:0];
                    we_d        = mem_rw;
                    maddr_d     = {addr[31:2], 2'b00};
                    be_d        = be_c;
                    mwdata_d    = wlane_c;
                    cnt_d       = '0;
                    rdata_d     = '0;
                    err_d       = misalign_c;
                    state_d     = misalign_c ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    rdata_d = lat_rw_q ? '0 : load_ext_c;
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lat_rw_q    <= 1'b0;
            lat_width_q <= 2'd0;
            lat_uns_q   <= 1'b0;
            lat_off_q   <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
            be_q        <= '0;
            mwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_rw_q    <= lat_rw_d;
            lat_width_q <= lat_width_d;
            lat_uns_q   <= lat_uns_d;
            lat_off_q   <= lat_off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            req_q       <= req_d;
            we_q        <= we_d;
            maddr_q     <= maddr_d;
            be_q        <= be_d;
            mwdata_q    <= mwdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;
    localparam int unsigned TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_rw = 1'b0;
    logic [1:0]  mem_width = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .mem_rw       (mem_rw),
        .mem_width    (mem_width),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .mem          (mem_bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge of the first post-start cycle.
    task automatic start_op(input logic rw, input logic [1:0] w, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        start = 1'b1; mem_rw = rw; mem_width = w; mem_unsigned = uns; addr = a; wdata = wd;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Hold off n cycles, then ack for one cycle; returns in the cycle after the ack.
    task automatic ack_after(input int n, input logic [31:0] rd);
        repeat (n) @(negedge clock);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = rd;
        @(negedge clock);
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        #12;
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_err",   32'(err), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_req",   32'(mem_bus.mem_req), 32'h0);
        check("rst_be",    32'(mem_bus.mem_be), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // LW 0x104, ack two cycles after request
        start_op(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0);
        check("lw_req",   32'(mem_bus.mem_req), 32'h1);
        check("lw_busy",  32'(busy), 32'h1);
        check("lw_addr",  mem_bus.mem_addr, 32'h0000_0104);
        check("lw_be",    32'(mem_bus.mem_be), 32'hF);
        check("lw_we",    32'(mem_bus.mem_we), 32'h0);
        ack_after(2, 32'hDEAD_BEEF);
        check("lw_done",  32'(done), 32'h1);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);
        check("lw_err",   32'(err), 32'h0);
        check("lw_req_off", 32'(mem_bus.mem_req), 32'h0);
        @(negedge clock);
        check("lw_done_once", 32'(done), 32'h0);
        check("lw_idle",      32'(busy), 32'h0);
        check("lw_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Ack in IDLE must not start anything
        mem_bus.mem_ack = 1'b1;
        @(negedge clock);
        mem_bus.mem_ack = 1'b0;
        check("idle_ack_done", 32'(done), 32'h0);
        check("idle_ack_busy", 32'(busy), 32'h0);

        // LB / LBU at offset 3, ack in first REQ cycle
        start_op(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0);
        check("lb_be",   32'(mem_bus.mem_be), 32'h8);
        check("lb_addr", mem_bus.mem_addr, 32'h0000_0100);
        ack_after(0, 32'h80AA_BBCC);
        check("lb_done",  32'(done), 32'h1);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        start_op(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0);
        ack_after(0, 32'h80AA_BBCC);
        check("lbu_rdata", rdata, 32'h0000_0080);

        // LH / LHU on both halves
        start_op(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0);
        check("lh_be", 32'(mem_bus.mem_be), 32'hC);
        ack_after(0, 32'h8001_7FFF);
        check("lh_rdata", rdata, 32'hFFFF_8001);
        start_op(1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0);
        check("lhu_be", 32'(mem_bus.mem_be), 32'h3);
        ack_after(0, 32'h8001_7FFF);
        check("lhu_rdata", rdata, 32'h0000_7FFF);

        // SH 0x202; a start during REQ is ignored
        start_op(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
        check("sh_we",    32'(mem_bus.mem_we), 32'h1);
        check("sh_be",    32'(mem_bus.mem_be), 32'hC);
        check("sh_wdata", mem_bus.mem_wdata, 32'hABCD_ABCD);
        start = 1'b1; addr = 32'h0000_0300; wdata = 32'h0;
        @(negedge clock);
        start = 1'b0;
        check("busy_start_addr",  mem_bus.mem_addr, 32'h0000_0200);
        check("busy_start_wdata", mem_bus.mem_wdata, 32'hABCD_ABCD);
        ack_after(0, 32'hFFFF_FFFF);
        check("sh_done",  32'(done), 32'h1);
        check("sh_rdata", rdata, 32'h0);

        // SB offset 1, and width 3 behaving as word
        start_op(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_005A);
        check("sb_be",    32'(mem_bus.mem_be), 32'h2);
        check("sb_wdata", mem_bus.mem_wdata, 32'h5A5A_5A5A);
        ack_after(0, 32'h0);
        start_op(1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'hCAFE_F00D);
        check("w3_be",    32'(mem_bus.mem_be), 32'hF);
        check("w3_wdata", mem_bus.mem_wdata, 32'hCAFE_F00D);
        ack_after(0, 32'h0);

        // Timeout: no ack at all
        start_op(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0);
        cyc = 0;
        while (mem_bus.mem_req && cyc < 40) begin
            cyc++;
            @(negedge clock);
        end
        check("to_req_cycles", 32'(cyc), 32'(TIMEOUT));
        check("to_done",  32'(done), 32'h1);
        check("to_err",   32'(err), 32'h1);
        check("to_rdata", rdata, 32'h0);
        @(negedge clock);
        check("to_err_hold", 32'(err), 32'h1);

        // Ack on the last allowed cycle wins over the timeout
        start_op(1'b0, 2'd2, 1'b0, 32'h0000_0408, 32'h0);
        check("err_cleared", 32'(err), 32'h0);
        ack_after(int'(TIMEOUT) - 1, 32'h1122_3344);
        check("late_ack_done",  32'(done), 32'h1);
        check("late_ack_err",   32'(err), 32'h0);
        check("late_ack_rdata", rdata, 32'h1122_3344);

        // Misaligned LW 0x101
        start_op(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_req",   32'(mem_bus.mem_req), 32'h0);
        check("mis_done",  32'(done), 32'h1);
        check("mis_err",   32'(err), 32'h1);
        check("mis_rdata", rdata, 32'h0);
        @(negedge clock);
        check("mis_idle",  32'(busy), 32'h0);
`else
        check("mis_req",  32'(mem_bus.mem_req), 32'h1);
        check("mis_addr", mem_bus.mem_addr, 32'h0000_0100);
        check("mis_be",   32'(mem_bus.mem_be), 32'hF);
        ack_after(0, 32'h55AA_55AA);
        check("mis_err",   32'(err), 32'h0);
        check("mis_rdata", rdata, 32'h55AA_55AA);
`endif

        // Asynchronous reset in the middle of REQ
        start_op(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req",  32'(mem_bus.mem_req), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        start_op(1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'h0);
        check("post_rst_addr", mem_bus.mem_addr, 32'h0000_0504);
        ack_after(1, 32'h0BAD_F00D);
        check("post_rst_done",  32'(done), 32'h1);
        check("post_rst_rdata", rdata, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
